// File: rtl/tlb_array.sv
// tlb_array: LoongArch TLB storage with two registered search ports,
// a tlbwr/tlbrd port and an invtlb engine (TLB_INVTLB_FAST_EN: 1-cycle invtlb).
module tlb_array #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s0_req,
  input  logic [18:0]      s0_vppn,
  input  logic             s0_va_bit12,
  input  logic [9:0]       s0_asid,
  output logic             s0_valid,
  output logic             s0_found,
  output logic [IDX_W-1:0] s0_index,
  output logic [19:0]      s0_ppn,
  output logic [5:0]       s0_ps,
  output logic [1:0]       s0_plv,
  output logic [1:0]       s0_mat,
  output logic             s0_d,
  output logic             s0_v,
  input  logic             s1_req,
  input  logic [18:0]      s1_vppn,
  input  logic             s1_va_bit12,
  input  logic [9:0]       s1_asid,
  output logic             s1_valid,
  output logic             s1_found,
  output logic [IDX_W-1:0] s1_index,
  output logic [19:0]      s1_ppn,
  output logic [5:0]       s1_ps,
  output logic [1:0]       s1_plv,
  output logic [1:0]       s1_mat,
  output logic             s1_d,
  output logic             s1_v,
  input  logic             we,
  input  logic [IDX_W-1:0] w_index,
  input  logic             w_e,
  input  logic             w_g,
  input  logic [18:0]      w_vppn,
  input  logic [5:0]       w_ps,
  input  logic [9:0]       w_asid,
  input  logic [19:0]      w_ppn0,
  input  logic [19:0]      w_ppn1,
  input  logic [1:0]       w_plv0,
  input  logic [1:0]       w_mat0,
  input  logic [1:0]       w_plv1,
  input  logic [1:0]       w_mat1,
  input  logic             w_d0,
  input  logic             w_v0,
  input  logic             w_d1,
  input  logic             w_v1,
  input  logic [IDX_W-1:0] r_index,
  output logic             r_e,
  output logic [18:0]      r_vppn,
  output logic [5:0]       r_ps,
  output logic [9:0]       r_asid,
  output logic             r_g,
  output logic [19:0]      r_ppn0,
  output logic [19:0]      r_ppn1,
  output logic [1:0]       r_plv0,
  output logic [1:0]       r_plv1,
  output logic [1:0]       r_mat0,
  output logic [1:0]       r_mat1,
  output logic             r_d0,
  output logic             r_d1,
  output logic             r_v0,
  output logic             r_v1,
  input  logic             invtlb_valid,
  input  logic [4:0]       invtlb_op,
  input  logic [9:0]       invtlb_asid,
  input  logic [18:0]      invtlb_vppn,
  output logic             invtlb_busy,
  output logic             invtlb_done
);

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } ent_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    logic [19:0]      ppn;
    logic [5:0]       ps;
    logic [1:0]       plv;
    logic [1:0]       mat;
    logic             d;
    logic             v;
  } res_t;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TLBNUM - 1);

  ent_t              ent_q [TLBNUM];
  ent_t              w_ent;
  ent_t              r_ent;
  res_t              s0_d_res, s1_d_res;
  res_t              s0_q, s1_q;
  logic              s0_valid_q, s1_valid_q;
  logic [TLBNUM-1:0] clr_d;
  state_t            state_q;
  logic              busy_q, done_q;
`ifndef TLB_INVTLB_FAST_EN
  logic [IDX_W-1:0]  ptr_q;
  logic [4:0]        op_q;
  logic [9:0]        iasid_q;
  logic [18:0]       ivppn_q;
`endif

  // A 4MB page pair (ps 21) only compares VA[31:22]
  function automatic logic vppn_hit(input ent_t x, input logic [18:0] vppn);
    logic h;
    if (x.ps == 6'd21) h = (x.vppn[18:9] == vppn[18:9]);
    else               h = (x.vppn == vppn);
    return h;
  endfunction

  function automatic logic s_hit(input ent_t x, input logic [18:0] vppn,
                                 input logic [9:0] asid);
    return x.e && (x.g || x.asid == asid) && vppn_hit(x, vppn);
  endfunction

  function automatic res_t s_pick(input ent_t x, input logic [IDX_W-1:0] idx,
                                  input logic [18:0] vppn, input logic bit12);
    res_t r;
    logic odd;
    odd     = (x.ps == 6'd21) ? vppn[8] : bit12;
    r.found = 1'b1;
    r.index = idx;
    r.ps    = x.ps;
    r.ppn   = odd ? x.ppn1 : x.ppn0;
    r.plv   = odd ? x.plv1 : x.plv0;
    r.mat   = odd ? x.mat1 : x.mat0;
    r.d     = odd ? x.d1   : x.d0;
    r.v     = odd ? x.v1   : x.v0;
    return r;
  endfunction

  function automatic logic inv_hit(input ent_t x, input logic [4:0] op,
                                   input logic [9:0] asid,
                                   input logic [18:0] vppn);
    logic am, vm, h;
    am = (x.asid == asid);
    vm = vppn_hit(x, vppn);
    case (op)
      5'd0, 5'd1: h = 1'b1;
      5'd2:       h = x.g;
      5'd3:       h = !x.g;
      5'd4:       h = !x.g && am;
      5'd5:       h = !x.g && am && vm;
      5'd6:       h = (x.g || am) && vm;
      default:    h = 1'b0;
    endcase
    return h;
  endfunction

  assign w_ent = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                   ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0,
                   d0: w_d0, v0: w_v0,
                   ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1,
                   d1: w_d1, v1: w_v1};

  assign r_ent  = ent_q[r_index];
  assign r_e    = r_ent.e;
  assign r_vppn = r_ent.vppn;
  assign r_ps   = r_ent.ps;
  assign r_asid = r_ent.asid;
  assign r_g    = r_ent.g;
  assign r_ppn0 = r_ent.ppn0;
  assign r_ppn1 = r_ent.ppn1;
  assign r_plv0 = r_ent.plv0;
  assign r_plv1 = r_ent.plv1;
  assign r_mat0 = r_ent.mat0;
  assign r_mat1 = r_ent.mat1;
  assign r_d0   = r_ent.d0;
  assign r_d1   = r_ent.d1;
  assign r_v0   = r_ent.v0;
  assign r_v1   = r_ent.v1;

  // Priority lookup for both ports; scanning downwards leaves the lowest hit
  always_comb begin
    s0_d_res = '0;
    s1_d_res = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (s_hit(ent_q[i], s0_vppn, s0_asid))
        s0_d_res = s_pick(ent_q[i], IDX_W'(i), s0_vppn, s0_va_bit12);
      if (s_hit(ent_q[i], s1_vppn, s1_asid))
        s1_d_res = s_pick(ent_q[i], IDX_W'(i), s1_vppn, s1_va_bit12);
    end
  end

  // Per-entry invalidate strobes from the invtlb engine
  always_comb begin
    clr_d = '0;
`ifdef TLB_INVTLB_FAST_EN
    if (state_q == S_IDLE && invtlb_valid)
      for (int i = 0; i < TLBNUM; i++)
        clr_d[i] = inv_hit(ent_q[i], invtlb_op, invtlb_asid, invtlb_vppn);
`else
    if (state_q == S_SWEEP)
      clr_d[ptr_q] = inv_hit(ent_q[ptr_q], op_q, iasid_q, ivppn_q);
`endif
  end

  // Entry storage: invalidate first so a same-edge write takes precedence
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) ent_q[i].e <= 1'b0;
    end else begin
      for (int i = 0; i < TLBNUM; i++)
        if (clr_d[i]) ent_q[i].e <= 1'b0;
      if (we) ent_q[w_index] <= w_ent;
    end
  end

  // Registered search results, held until the next request
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s0_q       <= '0;
      s1_q       <= '0;
    end else begin
      s0_valid_q <= s0_req;
      s1_valid_q <= s1_req;
      if (s0_req) s0_q <= s0_d_res;
      if (s1_req) s1_q <= s1_d_res;
    end
  end

  // invtlb engine: accept in IDLE, sweep one entry per cycle, pulse done
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef TLB_INVTLB_FAST_EN
      ptr_q   <= '0;
      op_q    <= '0;
      iasid_q <= '0;
      ivppn_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (invtlb_valid) begin
`ifdef TLB_INVTLB_FAST_EN
            state_q <= S_DONE;
            done_q  <= 1'b1;
`else
            state_q <= S_SWEEP;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
            op_q    <= invtlb_op;
            iasid_q <= invtlb_asid;
            ivppn_q <= invtlb_vppn;
`endif
          end
        end
        S_SWEEP: begin
`ifdef TLB_INVTLB_FAST_EN
          state_q <= S_IDLE;
`else
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`endif
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s0_valid    = s0_valid_q;
  assign s0_found    = s0_q.found;
  assign s0_index    = s0_q.index;
  assign s0_ppn      = s0_q.ppn;
  assign s0_ps       = s0_q.ps;
  assign s0_plv      = s0_q.plv;
  assign s0_mat      = s0_q.mat;
  assign s0_d        = s0_q.d;
  assign s0_v        = s0_q.v;
  assign s1_valid    = s1_valid_q;
  assign s1_found    = s1_q.found;
  assign s1_index    = s1_q.index;
  assign s1_ppn      = s1_q.ppn;
  assign s1_ps       = s1_q.ps;
  assign s1_plv      = s1_q.plv;
  assign s1_mat      = s1_q.mat;
  assign s1_d        = s1_q.d;
  assign s1_v        = s1_q.v;
  assign invtlb_busy = busy_q;
  assign invtlb_done = done_q;

endmodule

// File: tb/tb_tlb_array.sv
// tb_tlb_array: scoreboard bench for tlb_array against a
// VA-arithmetic reference model of the TLB.
module tb_tlb_array;
  localparam int N = 16;
`ifdef TLB_INVTLB_FAST_EN
  localparam int EXP_DONE = 1;
  localparam int EXP_BUSY = 0;
`else
  localparam int EXP_DONE = N + 1;
  localparam int EXP_BUSY = N;
`endif

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } ment_t;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } sres_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        s0_req, s1_req;
  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_valid, s0_found, s0_d, s0_v;
  logic        s1_valid, s1_found, s1_d, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0]  s0_ps, s1_ps;
  logic [1:0]  s0_plv, s0_mat, s1_plv, s1_mat;
  logic        we;
  logic [3:0]  w_index;
  logic        w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
  logic [3:0]  r_index;
  logic        r_e, r_g, r_d0, r_d1, r_v0, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic [9:0]  invtlb_asid;
  logic [18:0] invtlb_vppn;
  logic        invtlb_busy, invtlb_done;

  tlb_array #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12),
    .s0_asid(s0_asid), .s0_valid(s0_valid), .s0_found(s0_found),
    .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
    .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12),
    .s1_asid(s1_asid), .s1_valid(s1_valid), .s1_found(s1_found),
    .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
    .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_e(w_e), .w_g(w_g),
    .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid),
    .w_ppn0(w_ppn0), .w_ppn1(w_ppn1),
    .w_plv0(w_plv0), .w_mat0(w_mat0), .w_plv1(w_plv1), .w_mat1(w_mat1),
    .w_d0(w_d0), .w_v0(w_v0), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
    .r_asid(r_asid), .r_g(r_g), .r_ppn0(r_ppn0), .r_ppn1(r_ppn1),
    .r_plv0(r_plv0), .r_plv1(r_plv1), .r_mat0(r_mat0), .r_mat1(r_mat1),
    .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .invtlb_asid(invtlb_asid), .invtlb_vppn(invtlb_vppn),
    .invtlb_busy(invtlb_busy), .invtlb_done(invtlb_done)
  );

  ment_t       mdl [N];
  sres_t       q0 [$];
  sres_t       q1 [$];
  int          checks = 0;
  int          failures = 0;
  logic        pend_we = 1'b0;
  logic [3:0]  pend_idx;
  ment_t       pend_ent;
  logic [18:0] pool [4] = '{19'h12345, 19'h40000, 19'h2AAAA, 19'h7FE00};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Page match on the full VA: both halves of a pair share VA[31:ps+1]
  function automatic logic va_match(input ment_t x, input logic [18:0] v);
    logic [31:0] va, ev;
    int sh;
    va = {v, 13'h0};
    ev = {x.vppn, 13'h0};
    sh = int'(x.ps) + 1;
    return (va >> sh) == (ev >> sh);
  endfunction

  function automatic sres_t ref_search(input logic [18:0] v, input logic b,
                                       input logic [9:0] a);
    sres_t r;
    logic [31:0] va;
    logic odd;
    r = '0;
    va = {v, b, 12'h0};
    for (int i = 0; i < N; i++) begin
      if (mdl[i].e && (mdl[i].g || mdl[i].asid == a) && va_match(mdl[i], v)) begin
        odd = va[mdl[i].ps];
        r.found = 1'b1;
        r.index = 4'(i);
        r.ps    = mdl[i].ps;
        r.ppn   = odd ? mdl[i].ppn1 : mdl[i].ppn0;
        r.plv   = odd ? mdl[i].plv1 : mdl[i].plv0;
        r.mat   = odd ? mdl[i].mat1 : mdl[i].mat0;
        r.d     = odd ? mdl[i].d1 : mdl[i].d0;
        r.v     = odd ? mdl[i].v1 : mdl[i].v0;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic ref_inv(input ment_t x, input int op,
                                   input logic [9:0] a, input logic [18:0] v);
    logic gm, am, vm;
    gm = x.g;
    am = (x.asid == a);
    vm = va_match(x, v);
    if (op <= 1) return 1'b1;
    if (op == 2) return gm;
    if (op == 3) return !gm;
    if (op == 4) return !gm && am;
    if (op == 5) return !gm && am && vm;
    if (op == 6) return (gm || am) && vm;
    return 1'b0;
  endfunction

  function automatic ment_t rand_ent(input logic force_e);
    ment_t x;
    x.e    = force_e ? 1'b1 : ($urandom_range(3) != 0);
    x.vppn = pool[$urandom_range(3)];
    x.ps   = $urandom_range(1) ? 6'd21 : 6'd12;
    x.asid = $urandom_range(1) ? 10'd5 : 10'd6;
    x.g    = 1'($urandom_range(1));
    x.ppn0 = 20'($urandom);
    x.ppn1 = 20'($urandom);
    x.plv0 = 2'($urandom);
    x.mat0 = 2'($urandom);
    x.plv1 = 2'($urandom);
    x.mat1 = 2'($urandom);
    x.d0   = 1'($urandom);
    x.v0   = 1'($urandom);
    x.d1   = 1'($urandom);
    x.v1   = 1'($urandom);
    return x;
  endfunction

  task automatic set_write(input logic [3:0] idx, input ment_t x);
    we = 1'b1; w_index = idx;
    w_e = x.e; w_vppn = x.vppn; w_ps = x.ps; w_asid = x.asid; w_g = x.g;
    w_ppn0 = x.ppn0; w_plv0 = x.plv0; w_mat0 = x.mat0;
    w_d0 = x.d0; w_v0 = x.v0;
    w_ppn1 = x.ppn1; w_plv1 = x.plv1; w_mat1 = x.mat1;
    w_d1 = x.d1; w_v1 = x.v1;
    pend_we = 1'b1; pend_idx = idx; pend_ent = x;
  endtask

  task automatic srch0(input logic [18:0] v, input logic b, input logic [9:0] a);
    s0_req = 1'b1; s0_vppn = v; s0_va_bit12 = b; s0_asid = a;
    q0.push_back(ref_search(v, b, a));
  endtask

  task automatic srch1(input logic [18:0] v, input logic b, input logic [9:0] a);
    s1_req = 1'b1; s1_vppn = v; s1_va_bit12 = b; s1_asid = a;
    q1.push_back(ref_search(v, b, a));
  endtask

  task automatic tick();
    @(posedge clk);
    if (pend_we) mdl[pend_idx] = pend_ent;
    pend_we = 1'b0;
    @(negedge clk);
    we = 1'b0; s0_req = 1'b0; s1_req = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] idx);
    ment_t rd;
    r_index = idx;
    #1;
    rd = {r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0,
          r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1};
    chk($sformatf("read[%0d]", idx), rd, mdl[idx]);
  endtask

  task automatic rand_search(output logic [18:0] v, output logic b,
                             output logic [9:0] a);
    v = pool[$urandom_range(3)];
    if ($urandom_range(1) == 1) v[8:0] = 9'($urandom);
    b = 1'($urandom);
    a = $urandom_range(1) ? 10'd5 : 10'd6;
  endtask

  task automatic run_inv(input int op, input logic [9:0] a, input logic [18:0] v);
    int busy_cnt, done_at;
    busy_cnt = 0; done_at = 0;
    invtlb_valid = 1'b1; invtlb_op = 5'(op);
    invtlb_asid = a; invtlb_vppn = v;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (invtlb_busy) busy_cnt++;
      if (invtlb_done) begin
        done_at = k;
        break;
      end
    end
    invtlb_valid = 1'b0;
    chk($sformatf("inv_done_cycle op%0d", op), 128'(done_at), 128'(EXP_DONE));
    chk($sformatf("inv_busy_cycles op%0d", op), 128'(busy_cnt), 128'(EXP_BUSY));
    @(negedge clk);
    chk("inv_done_pulse", 128'(invtlb_done), 128'(0));
    for (int i = 0; i < N; i++)
      if (mdl[i].e && ref_inv(mdl[i], op, a, v)) mdl[i].e = 1'b0;
    for (int i = 0; i < N; i++) rd_check(4'(i));
  endtask

  // Monitor: every presented result is matched against the oldest expectation
  always @(negedge clk) begin
    sres_t got;
    if (s0_valid) begin
      got = {s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v};
      if (q0.size() == 0) chk("s0_unexpected_valid", 128'(1), 128'(0));
      else chk("s0_result", got, q0.pop_front());
    end
    if (s1_valid) begin
      got = {s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v};
      if (q1.size() == 0) chk("s1_unexpected_valid", 128'(1), 128'(0));
      else chk("s1_result", got, q1.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    ment_t x;
    logic [18:0] v;
    logic b;
    logic [9:0] a;
    int done_seen;
    resetn = 1'b0; we = 1'b0; w_index = '0;
    {w_e, w_g, w_vppn, w_ps, w_asid, w_ppn0, w_ppn1} = '0;
    {w_plv0, w_mat0, w_plv1, w_mat1, w_d0, w_v0, w_d1, w_v1} = '0;
    s0_req = 1'b0; s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
    s1_req = 1'b0; s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
    r_index = '0; invtlb_valid = 1'b0; invtlb_op = '0;
    invtlb_asid = '0; invtlb_vppn = '0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s0_valid", 128'(s0_valid), 128'(0));
    chk("rst_s1_valid", 128'(s1_valid), 128'(0));
    chk("rst_s0_found", 128'(s0_found), 128'(0));
    chk("rst_s1_found", 128'(s1_found), 128'(0));
    chk("rst_busy", 128'(invtlb_busy), 128'(0));
    chk("rst_done", 128'(invtlb_done), 128'(0));
    for (int i = 0; i < N; i++) begin
      r_index = 4'(i);
      #1;
      chk($sformatf("rst_e[%0d]", i), 128'(r_e), 128'(0));
    end
    resetn = 1'b1;
    for (int i = 0; i < N; i++) begin
      x = rand_ent(1'b0);
      x.e = 1'b0;
      set_write(4'(i), x);
      tick();
    end
    for (int i = 0; i < N; i++) rd_check(4'(i));

    x = '0;
    x.e = 1'b1; x.vppn = 19'h12345; x.ps = 6'd12; x.asid = 10'd5;
    x.ppn0 = 20'hAAAAA; x.ppn1 = 20'hBBBBB; x.v0 = 1'b1;
    set_write(4'd3, x);
    tick();
    srch0(19'h12345, 1'b0, 10'd5);
    tick();
    chk("t1_found", 128'(s0_found), 128'(1));
    chk("t1_index", 128'(s0_index), 128'(3));
    chk("t1_ppn0", 128'(s0_ppn), 128'(20'hAAAAA));
    srch0(19'h12345, 1'b1, 10'd5);
    tick();
    chk("t1_ppn1", 128'(s0_ppn), 128'(20'hBBBBB));
    srch0(19'h12345, 1'b0, 10'd6);
    tick();
    chk("t1_miss_found", 128'(s0_found), 128'(0));
    chk("t1_miss_ppn", 128'(s0_ppn), 128'(0));

    x = '0;
    x.e = 1'b1; x.vppn = 19'h40000; x.ps = 6'd21; x.g = 1'b1;
    x.ppn0 = 20'h66666; x.ppn1 = 20'h77777; x.v1 = 1'b1;
    set_write(4'd7, x);
    tick();
    srch1(19'h401FF, 1'b0, 10'd9);
    tick();
    chk("t2_found", 128'(s1_found), 128'(1));
    chk("t2_index", 128'(s1_index), 128'(7));
    chk("t2_ppn_odd", 128'(s1_ppn), 128'(20'h77777));

    x = '0;
    x.e = 1'b1; x.vppn = 19'h2AAAA; x.ps = 6'd12; x.g = 1'b1;
    x.ppn0 = 20'h22222;
    set_write(4'd2, x);
    tick();
    set_write(4'd9, x);
    tick();
    srch0(19'h2AAAA, 1'b0, 10'd1);
    tick();
    chk("t3_lowest_index", 128'(s0_index), 128'(2));
    x.ppn0 = 20'h33333;
    set_write(4'd2, x);
    srch0(19'h2AAAA, 1'b0, 10'd1);
    tick();
    chk("t3_old_contents", 128'(s0_ppn), 128'(20'h22222));
    rd_check(4'd2);
    srch1(19'h2AAAA, 1'b0, 10'd1);
    tick();
    chk("t3_new_contents", 128'(s1_ppn), 128'(20'h33333));

    for (int it = 0; it < 300; it++) begin
      rd_check(4'($urandom));
      if ($urandom_range(2) == 0) set_write(4'($urandom), rand_ent(1'b0));
      if ($urandom_range(1) == 1) begin
        rand_search(v, b, a);
        srch0(v, b, a);
      end
      if ($urandom_range(1) == 1) begin
        rand_search(v, b, a);
        srch1(v, b, a);
      end
      tick();
    end

    for (int i = 0; i < N; i++) begin
      x = rand_ent(1'b1);
      x.e = (i == 1 || i == 4 || i == 6 || i == 8);
      x.g = (i == 6);
      x.asid = (i == 8) ? 10'd7 : 10'd5;
      set_write(4'(i), x);
      tick();
    end
    run_inv(4, 10'd5, 19'h0);
    r_index = 4'd1; #1; chk("op4_e1", 128'(r_e), 128'(0));
    r_index = 4'd4; #1; chk("op4_e4", 128'(r_e), 128'(0));
    r_index = 4'd6; #1; chk("op4_e6", 128'(r_e), 128'(1));
    @(negedge clk);

    for (int i = 0; i < N; i++) begin
      set_write(4'(i), rand_ent(1'b1));
      tick();
    end
    run_inv(9, 10'd5, 19'h12345);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        set_write(4'(i), rand_ent(1'b0));
        tick();
      end
      rand_search(v, b, a);
      run_inv($urandom_range(9), a, v);
    end

    for (int i = 0; i < N; i++) begin
      set_write(4'(i), rand_ent(1'b1));
      tick();
    end
    invtlb_valid = 1'b1; invtlb_op = 5'd0;
    @(posedge clk);
    repeat (4) @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    invtlb_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < N; i++) mdl[i].e = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_sweep_busy", 128'(invtlb_busy), 128'(0));
    done_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (invtlb_done || invtlb_busy) done_seen++;
    end
    chk("rst_sweep_no_done", 128'(done_seen), 128'(0));
    for (int i = 0; i < N; i++) rd_check(4'(i));

    @(negedge clk);
    chk("scoreboard_drained", 128'(q0.size() + q1.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tlb_array.md
Name: tlb_array

Overview:
- TLB storage and lookup block: the responder side of the WB-stage TLB write/read interface.
- Holds TLBNUM entries in the LoongArch format (vppn/ps/asid/g/e, two page halves).
- Serves two registered search ports: s0 for fetch and s1 for load/store/tlbsrch.
- Accepts tlbwr/tlbfill writes and tlbrd reads from WB.
- Executes invtlb as a multi-cycle sweep FSM with a busy/done handshake.

Parameters:
TLBNUM, 16, number of entries; must be a power of 2
IDX_W, 4, index width, equal to log2(TLBNUM)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
s0_req, s1_req  in  1  search request for port 0 / port 1
s0_vppn, s1_vppn  in  19  VA[31:13]
s0_va_bit12, s1_va_bit12  in  1  VA[12]
s0_asid, s1_asid  in  10  current ASID
s0_valid, s1_valid  out  1  search result valid, one-cycle pulse
s0_found, s1_found  out  1  hit
s0_index, s1_index  out  IDX_W  hit index
s0_ppn, s1_ppn  out  20  selected PPN
s0_ps, s1_ps  out  6  page size
s0_plv, s0_mat, s1_plv, s1_mat  out  2 each  selected PLV / MAT
s0_d, s0_v, s1_d, s1_v  out  1 each  selected D / V
we  in  1  write strobe
w_index  in  IDX_W  write index
w_e, w_g  in  1 each  entry E / G
w_vppn  in  19  VPPN
w_ps  in  6  page size
w_asid  in  10  ASID
w_ppn0, w_ppn1  in  20 each  PPN of half 0 / half 1
w_plv0, w_mat0, w_plv1, w_mat1  in  2 each  PLV / MAT of each half
w_d0, w_v0, w_d1, w_v1  in  1 each  D / V of each half
r_index  in  IDX_W  read index
r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  out  same widths as the w_* fields  read data
invtlb_valid  in  1  invtlb request
invtlb_op  in  5  invtlb op
invtlb_asid  in  10  ASID operand
invtlb_vppn  in  19  VA[31:13] operand
invtlb_busy  out  1  sweep in progress
invtlb_done  out  1  completion, one-cycle pulse

Behaviour:
- Reset (resetn=0 at posedge): all entry E bits cleared; other entry fields are not reset. s*_valid, s*_found, invtlb_busy and invtlb_done go to 0. FSM goes to IDLE. A reset mid-sweep aborts the sweep.
- Write: at posedge with we=1, every field of entry[w_index] is updated. The write is accepted in any FSM state. If the sweep clears the same entry in the same cycle, the write wins.
- Read: combinational from r_index against the current array. A write in cycle t is visible on the read port at t+1.
- Search: s*_req is sampled at posedge t. The result is registered and presented during cycle t+1 with s*_valid=1 for that single cycle. Results hold until the next request. The lookup sees the array as it was before any write landing on the same edge.
- Hit condition: e && (g || asid==s_asid) && VPPN match.
  - VPPN match when ps==12: full 19-bit compare.
  - VPPN match when ps==21: compare vppn[18:9] only.
- Odd-half select: va_bit12 when ps==12; s_vppn[8] when ps==21. Half 1 when the select bit is 1, otherwise half 0.
- Multiple hits: the lowest index wins.
- Miss: found=0, and index, ppn, ps, plv, mat, d, v are all 0.
- Both ports operate independently in the same cycle.
- invtlb FSM states:
  - IDLE: invtlb_valid is sampled only here. On accept at edge t, op, asid and vppn are latched, ptr=0, and the state goes to SWEEP.
  - SWEEP: cycles t+1 .. t+TLBNUM, invtlb_busy=1. Each cycle clears E of entry[ptr] if it matches the op; ptr increments. When ptr reaches TLBNUM-1 the state goes to DONE.
  - DONE: cycle t+TLBNUM+1, invtlb_done=1, busy=0. Returns to IDLE.
- invtlb_valid during SWEEP or DONE is ignored; the requester must hold it until done.
- invtlb op match (gm = entry g, am = asid match, vm = vppn match using the ps rule above):
  - op 0, 1: all entries.
  - op 2: gm=1.
  - op 3: gm=0.
  - op 4: !gm && am.
  - op 5: !gm && am && vm.
  - op 6: (gm || am) && vm.
  - op 7..31: no entries match; the full sweep still runs and done still pulses.
- Searches during a sweep are allowed and see the partially swept state.

Optional Feature:
TLB_INVTLB_FAST_EN
- Defined: invtlb clears all matching entries at the accept edge. invtlb_busy is constant 0, and invtlb_done pulses in cycle t+1. Any write to the same index on that edge still wins.
- Undefined: the TLBNUM-cycle sweep described above.

Test Plan:
- Write idx 3 {e=1, vppn=0x12345, ps=12, asid=5, g=0, ppn0=0xAAAAA, ppn1=0xBBBBB, v0=1}; search s0 vppn=0x12345, bit12=0, asid=5 -> next cycle s0_valid=1, found=1, index=3, ppn=0xAAAAA; same search with bit12=1 -> ppn=0xBBBBB; same search with asid=6 -> found=0, ppn=0.
- Write idx 7 {e=1, vppn=0x40000, ps=21, g=1}; s1 search vppn=0x401FF, asid=9 -> found=1, index=7, half selected by vppn[8]=1.
- Identical entries at idx 2 and 9 -> search returns index=2. Write to idx 2 and search on the same edge -> old idx 2 contents returned.
- invtlb op=4, asid=5 with g=0/asid=5 entries at 1 and 4 and a g=1 entry at 6 -> busy for 16 cycles, done pulse at t+17, entries 1 and 4 have E=0, entry 6 is unchanged.
- invtlb op=0 with reset asserted at sweep cycle 5 -> busy=0, done never pulses, all E=0.
- invtlb op=9 -> no entry changes, done pulses at t+17. With TLB_INVTLB_FAST_EN defined, op=0 -> done pulses at t+1 and busy stays 0.
